ro_read_responder: RTL

- Responder end of the RO-stage memory read request (addr/size/len plus the subtask tag).
- Accepts one burst request from an RO subtask, splits it into single-beat 64-bit memory reads and collects the in-order returns.
- Emits one response subtask per returned word, carrying task, subtype, word_id, cq_slot and a last marker.
- Sits between the RO subtask scheduler and the tile's L1/memory read port.

---
 rtl/ro_read_responder_if.sv | 63 ++++++
 rtl/ro_read_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_read_responder_if.sv
// ro_read_responder_if
//   Bundles the three handshake groups seen by the RO read responder:
//     req_*  : burst request from the RO subtask scheduler
//     mem_*  : single-beat read port toward the tile L1/memory
//     resp_* : one response subtask per returned word
//   Modports:
//     slave  : the responder's view (accepts req, drives mem AR, drives resp)
//     master : the environment's view (scheduler + memory + consumer)
//   The TASK_W / SUBTYPE_W / CQ_SLOT_W parameters must match the ones given
//   to ro_read_responder.
interface ro_read_responder_if #(
  parameter int TASK_W    = 16,
  parameter int SUBTYPE_W = 4,
  parameter int CQ_SLOT_W = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic [2:0]           req_size;
  logic [7:0]           req_len;
  logic [TASK_W-1:0]    req_task;
  logic [SUBTYPE_W-1:0] req_subtype;
  logic                 req_mark_last;
  logic [CQ_SLOT_W-1:0] req_cq_slot;

  logic                 mem_arvalid;
  logic                 mem_arready;
  logic [31:0]          mem_araddr;
  logic                 mem_rvalid;
  logic [63:0]          mem_rdata;
  logic                 mem_rready;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [TASK_W-1:0]    resp_task;
  logic [SUBTYPE_W-1:0] resp_subtype;
  logic [63:0]          resp_data;
  logic [7:0]           resp_word_id;
  logic [CQ_SLOT_W-1:0] resp_cq_slot;
  logic                 resp_last;

  modport slave (
    input  req_valid, req_addr, req_size, req_len, req_task, req_subtype,
           req_mark_last, req_cq_slot,
    output req_ready,
    output mem_arvalid, mem_araddr, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata,
    output resp_valid, resp_task, resp_subtype, resp_data, resp_word_id,
           resp_cq_slot, resp_last,
    input  resp_ready
  );

  modport master (
    output req_valid, req_addr, req_size, req_len, req_task, req_subtype,
           req_mark_last, req_cq_slot,
    input  req_ready,
    input  mem_arvalid, mem_araddr, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata,
    input  resp_valid, resp_task, resp_subtype, resp_data, resp_word_id,
           resp_cq_slot, resp_last,
    output resp_ready
  );
endinterface

// File: rtl/ro_read_responder.sv
// ro_read_responder
//   Responder end of the RO-stage memory read. Accepts one burst request,
//   splits it into single-beat 64-bit reads, collects the in-order returns
//   into a response buffer and emits one response subtask per word.
//
//   Ports:
//     clk, rstn  : clock, asynchronous active-low reset
//     bus        : ro_read_responder_if.slave (req_*, mem_*, resp_* groups)
//     size_err   : sticky flag, set when a request arrives with a size other
//                  than 2 or 3 (such a burst is executed as size 3)
//     stat_beats : response handshakes, saturating  (RO_RESP_STATS_EN only)
//     stat_stall : cycles with resp_valid & !resp_ready, saturating
//                                                    (RO_RESP_STATS_EN only)
//
//   Optional feature macro: RO_RESP_STATS_EN adds the two statistics
//   counters; when undefined they do not exist and behaviour is unchanged.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | req_ready=1, waiting for a burst request
//   ISSUE  | issuing beat reads while in-flight and buffer space allow
//   DRAIN  | all beats issued; waiting for returns and the buffer to empty
module ro_read_responder #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_FIFO_DEPTH = 8,
  parameter int TASK_W          = 16,
  parameter int SUBTYPE_W       = 4,
  parameter int CQ_SLOT_W       = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  ro_read_responder_if.slave    bus,
  output logic                  size_err
`ifdef RO_RESP_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_stall
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;

  logic [31:0]          addr_q;
  logic                 size3_q;
  logic [7:0]           len_q;
  logic [TASK_W-1:0]    task_q;
  logic [SUBTYPE_W-1:0] subtype_q;
  logic                 mark_last_q;
  logic [CQ_SLOT_W-1:0] cq_slot_q;
  logic [8:0]           issue_idx_q;
  logic [8:0]           ret_idx_q;
  logic [OW-1:0]        outstanding_q;
  logic                 size_err_q;

  logic [63:0]          fifo_data [RESP_FIFO_DEPTH];
  logic [7:0]           fifo_wid  [RESP_FIFO_DEPTH];
  logic                 fifo_last [RESP_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        fifo_count_q;

  logic                 req_ready_int;
  logic                 mem_arvalid_int;
  logic                 resp_valid_int;
  logic                 req_fire, ar_fire, capture, resp_fire;
  logic                 issue_room;
  logic                 issue_last;
  logic                 ret_done;
  logic [31:0]          beat_addr;
  logic [63:0]          cap_data;
  logic                 cap_last;
  logic                 size_illegal;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_fire   = bus.req_valid & req_ready_int;
  assign ar_fire    = mem_arvalid_int & bus.mem_arready;
  // Returns with nothing outstanding belong to a burst killed by reset.
  assign capture    = bus.mem_rvalid & (outstanding_q != '0);
  assign resp_valid_int = (fifo_count_q != '0);
  assign resp_fire  = resp_valid_int & bus.resp_ready;

  // Buffer space is reserved at issue time so returns can never overflow it.
  assign issue_room = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                      ((int'(outstanding_q) + int'(fifo_count_q)) < RESP_FIFO_DEPTH);
  assign issue_last = (issue_idx_q == {1'b0, len_q});
  assign ret_done   = (ret_idx_q == ({1'b0, len_q} + 9'd1));

  assign beat_addr  = addr_q + (32'(issue_idx_q) << (size3_q ? 3 : 2));

  assign size_illegal = (bus.req_size != 3'd2) && (bus.req_size != 3'd3);

  // For 32-bit words the beat address advances in steps of 4, so bit 2 of
  // the returning beat's address is addr[2] toggled by the beat parity.
  assign cap_data = size3_q ? bus.mem_rdata
                  : ((addr_q[2] ^ ret_idx_q[0]) ? {32'h0, bus.mem_rdata[63:32]}
                                                : {32'h0, bus.mem_rdata[31:0]});
  assign cap_last = mark_last_q & (ret_idx_q == {1'b0, len_q});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    req_ready_int   = 1'b0;
    mem_arvalid_int = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_int = 1'b1;
        if (bus.req_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_arvalid_int = issue_room;
        if (issue_room && bus.mem_arready && issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the final response is taken so req_ready is up the
        // very next cycle.
        if (ret_done && ((fifo_count_q == '0) ||
                         ((fifo_count_q == CW'(1)) && resp_fire)))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q        <= '0;
      size3_q       <= 1'b0;
      len_q         <= '0;
      task_q        <= '0;
      subtype_q     <= '0;
      mark_last_q   <= 1'b0;
      cq_slot_q     <= '0;
      issue_idx_q   <= '0;
      ret_idx_q     <= '0;
      outstanding_q <= '0;
      size_err_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
    end else begin
      if (req_fire) begin
        addr_q      <= bus.req_addr;
        size3_q     <= (bus.req_size != 3'd2);
        len_q       <= bus.req_len;
        task_q      <= bus.req_task;
        subtype_q   <= bus.req_subtype;
        mark_last_q <= bus.req_mark_last;
        cq_slot_q   <= bus.req_cq_slot;
        issue_idx_q <= '0;
        ret_idx_q   <= '0;
        if (size_illegal) size_err_q <= 1'b1;
      end
      if (ar_fire) issue_idx_q <= issue_idx_q + 9'd1;
      if (capture) begin
        ret_idx_q <= ret_idx_q + 9'd1;
        wr_ptr_q  <= ptr_next(wr_ptr_q);
      end
      if (resp_fire) rd_ptr_q <= ptr_next(rd_ptr_q);

      case ({capture, resp_fire})
        2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase

      case ({ar_fire, capture})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Buffer storage needs no reset: every read of it is qualified by count.
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_data[wr_ptr_q] <= cap_data;
      fifo_wid[wr_ptr_q]  <= ret_idx_q[7:0];
      fifo_last[wr_ptr_q] <= cap_last;
    end
  end

  assign bus.req_ready    = req_ready_int;
  assign bus.mem_arvalid  = mem_arvalid_int;
  assign bus.mem_araddr   = mem_arvalid_int ? (beat_addr & 32'hFFFF_FFF8) : 32'h0;
  assign bus.mem_rready   = 1'b1;

  assign bus.resp_valid   = resp_valid_int;
  assign bus.resp_data    = resp_valid_int ? fifo_data[rd_ptr_q] : 64'h0;
  assign bus.resp_word_id = resp_valid_int ? fifo_wid[rd_ptr_q]  : 8'h0;
  assign bus.resp_last    = resp_valid_int & fifo_last[rd_ptr_q];
  assign bus.resp_task    = resp_valid_int ? task_q    : '0;
  assign bus.resp_subtype = resp_valid_int ? subtype_q : '0;
  assign bus.resp_cq_slot = resp_valid_int ? cq_slot_q : '0;

  assign size_err = size_err_q;

`ifdef RO_RESP_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (resp_fire && (stat_beats != 32'hFFFF_FFFF))
        stat_beats <= stat_beats + 32'd1;
      if (resp_valid_int && !bus.resp_ready && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
